// File: rtl/leaf_pkg.sv
// Shared definitions for the leaf interface output path.
// No logic of its own; packet geometry and arbiter state encoding.
// Consumers import with leaf_pkg::*.
package leaf_pkg;

    // Default leaf packet width; the MSB flags a valid packet to the BFT.
    localparam int PACKET_BITS_DEF = 49;
    localparam int PKT_VLD_BIT     = PACKET_BITS_DEF - 1;

    // IDLE: no burst owner; BURST: owner locked and counting packets.
    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

endpackage

// File: rtl/leaf_out_arbiter_rr_pick.sv
// Rotate-priority encoder: first set bit of vld_i at or after ptr_i, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the pick is used.
module leaf_out_arbiter_rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  vld_i,
    input  logic [IW-1:0] ptr_i,
    output logic          found_o,
    output logic [IW-1:0] idx_o
);

    // Walk the requesters starting at the pointer; the first valid one wins.
    always_comb begin
        int c;
        found_o = 1'b0;
        idx_o   = '0;
        c       = 0;
        for (int k = 0; k < N; k++) begin
            c = int'(ptr_i) + k;
            if (c >= N) begin
                c = c - N;
            end
            if (!found_o && vld_i[c]) begin
                found_o = 1'b1;
                idx_o   = IW'(c);
            end
        end
    end

endmodule

// File: rtl/leaf_out_arbiter.sv
// Round-robin share of the leaf-to-BFT output among NUM_REQ packet sources, bounded bursts.
// Latency: ack in the request cycle, packet on the registered output the cycle after.
// Backpressure: resend freezes output word, state and pointers and suppresses all acks.
module leaf_out_arbiter
    import leaf_pkg::*;
#(
    parameter int PACKET_BITS = PACKET_BITS_DEF,
    parameter int NUM_REQ     = 4,
    parameter int MAX_BURST   = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [PACKET_BITS*NUM_REQ-1:0]  req_pkt,
    input  logic [NUM_REQ-1:0]              req_vld,
    output logic [NUM_REQ-1:0]              req_ack,
    input  logic                            resend,
    output logic [PACKET_BITS-1:0]          dout_leaf_interface2bft,
    output logic [$clog2(NUM_REQ)-1:0]      grant_owner
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(MAX_BURST + 1);

    arb_state_e             state_q, state_d;
    logic [IW-1:0]          owner_q, owner_d;
    logic [IW-1:0]          rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [PACKET_BITS-1:0] dout_q, dout_d;

    logic                   cont;
    logic                   burst_end;
    logic [IW-1:0]          pick_ptr;
    logic                   pick_found;
    logic [IW-1:0]          pick_idx;
    logic                   grant_vld;
    logic [IW-1:0]          grant_idx;
    logic [PACKET_BITS-1:0] grant_pkt;

    // Requester index after i, wrapping at NUM_REQ (which need not be a power of two).
    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
        if (i == IW'(NUM_REQ - 1)) begin
            return '0;
        end
        return i + 1'b1;
    endfunction

    // The owner keeps the output while it still has packets and burst budget left.
    assign cont      = (state_q == BURST) && req_vld[owner_q] && (cnt_q < CW'(MAX_BURST));
    // A burst that cannot continue hands priority to the requester after the owner,
    // and the replacement is picked in the same cycle so no bubble is inserted.
    assign burst_end = (state_q == BURST) && !cont;
    assign pick_ptr  = burst_end ? next_idx(owner_q) : rr_ptr_q;

    leaf_out_arbiter_rr_pick #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_rr_pick (
        .vld_i   (req_vld),
        .ptr_i   (pick_ptr),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    // Acks are masked while reset is held so nothing is lost into a clearing register.
    assign grant_vld = reset && !resend && (cont || pick_found);
    assign grant_idx = cont ? owner_q : pick_idx;
    assign grant_pkt = req_pkt[int'(grant_idx)*PACKET_BITS +: PACKET_BITS];

    // State register: everything clears asynchronously and holds under resend via the _d logic.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
            dout_q   <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
            dout_q   <= dout_d;
        end
    end

    // Next-state: continue the burst, or close it and re-arbitrate in the same cycle.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        dout_d   = dout_q;
        if (!resend) begin
            // Payload is forwarded untouched; an empty cycle emits an all-zero word.
            dout_d = grant_vld ? grant_pkt : '0;
            if (cont) begin
                cnt_d = cnt_q + CW'(1);
            end else begin
                if (burst_end) begin
                    rr_ptr_d = next_idx(owner_q);
                end
                if (pick_found) begin
                    owner_d = pick_idx;
                    cnt_d   = CW'(1);
                    if (MAX_BURST == 1) begin
                        // Single-packet bursts never lock; rotate immediately.
                        state_d  = IDLE;
                        rr_ptr_d = next_idx(pick_idx);
                    end else begin
                        state_d = BURST;
                    end
                end else begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
        end
    end

    // Outputs: one-hot ack for the packet loaded this cycle, registered word and owner.
    always_comb begin
        req_ack = '0;
        if (grant_vld) begin
            req_ack[grant_idx] = 1'b1;
        end
    end

    assign dout_leaf_interface2bft = dout_q;
    assign grant_owner             = owner_q;

endmodule
